mmc1_ctrl: RTL

// - MMC1 mapper controller. Snoops CPU-bus writes to $8000-$FFFF through the 5-write serial port.
// - Holds the control, CHR0, CHR1 and PRG bank registers.
// - Turns these registers plus the live cpumc/ppumc addresses into the PRG bank, CHR bank,

---
 rtl/mmc1_ctrl_pkg.sv | 22 ++
 rtl/mmc1_ctrl_wr_detect.sv | 41 ++++
 rtl/mmc1_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/mmc1_ctrl_pkg.sv
// Shared constants and types for the MMC1 mapper controller.
package mmc1_ctrl_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;

  localparam logic [1:0] MIR_ONE0 = 2'd0;
  localparam logic [1:0] MIR_ONE1 = 2'd1;
  localparam logic [1:0] MIR_VERT = 2'd2;
  localparam logic [1:0] MIR_HORZ = 2'd3;

  localparam logic [4:0] CTRL_RST = 5'h0C;
  localparam logic [4:0] SR_INIT  = 5'b10000;

  typedef enum logic {
    WD_IDLE = 1'b0,
    WD_HELD = 1'b1
  } wd_state_e;

endpackage

// File: rtl/mmc1_ctrl_wr_detect.sv
// Turns a level write-active strobe into one accepted-write pulse, dropping
// edges that arrive within WR_GAP clocks of the last accepted one.
module mmc1_wr_detect
  import mmc1_ctrl_pkg::*;
#(
  parameter int WR_GAP = 32
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic wr_act_in,
  output logic wr_evt_out
);

  localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  wd_state_e       state_q;
  logic            act_q;
  logic [GW-1:0]   gap_q;
  logic            evt_raw;

  assign evt_raw    = (state_q == WD_IDLE) && wr_act_in && !act_q;
  assign wr_evt_out = evt_raw && (gap_q == '0);

  always_ff @(posedge clk_in) begin
    // sampled through reset so a write held across deassertion is not an edge
    act_q <= wr_act_in;
    if (rst_in) begin
      state_q <= WD_IDLE;
      gap_q   <= '0;
    end else begin
      case (state_q)
        WD_IDLE: if (evt_raw)    state_q <= WD_HELD;
        WD_HELD: if (!wr_act_in) state_q <= WD_IDLE;
        default:                 state_q <= WD_IDLE;
      endcase
      if (wr_evt_out)        gap_q <= GW'(WR_GAP - 1);
      else if (gap_q != '0)  gap_q <= gap_q - GW'(1);
    end
  end

endmodule

// File: rtl/mmc1_ctrl.sv
// MMC1 mapper: serial register port on $8000-$FFFF plus PRG/CHR/mirroring
// bank mapping from the live cpumc/ppumc addresses.
module mmc1_ctrl
  import mmc1_ctrl_pkg::*;
#(
  parameter  int PRG_BANKS = 16,
  parameter  int CHR_BANKS = 32,
  parameter  int WR_GAP    = 32,
  localparam int PRG_W     = $clog2(PRG_BANKS),
  localparam int CHR_W     = $clog2(CHR_BANKS)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             prg_nce_in,
  input  logic [14:0]      prg_a_in,
  input  logic             prg_r_nw_in,
  input  logic [7:0]       prg_d_in,
  input  logic [13:0]      chr_a_in,
  output logic [PRG_W-1:0] prg_bank_out,
  output logic [CHR_W-1:0] chr_bank_out,
  output logic             ciram_a10_out,
  output logic             wram_en_out,
  output logic [2:0]       sr_cnt_out
);

  localparam logic [PRG_W-1:0] PRG_LAST = PRG_W'(PRG_BANKS - 1);

  logic       wr_act, wr_evt;
  logic [4:0] sr_q, sr_d;
  logic [2:0] sr_cnt_q;
  logic [4:0] ctrl_q, chr0_q, chr1_q, prg_q;

  assign wr_act = ~prg_nce_in & ~prg_r_nw_in;

  mmc1_wr_detect #(.WR_GAP(WR_GAP)) u_wr_detect (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .wr_act_in (wr_act),
    .wr_evt_out(wr_evt)
  );

  assign sr_d = {prg_d_in[0], sr_q[4:1]};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sr_q     <= SR_INIT;
      sr_cnt_q <= '0;
      ctrl_q   <= CTRL_RST;
      chr0_q   <= '0;
      chr1_q   <= '0;
      prg_q    <= '0;
    end else if (wr_evt) begin
      if (prg_d_in[7]) begin
        sr_q     <= SR_INIT;
        sr_cnt_q <= '0;
        ctrl_q   <= ctrl_q | CTRL_RST;
      end else if (!sr_q[0]) begin
        sr_q     <= sr_d;
        sr_cnt_q <= sr_cnt_q + 3'd1;
      end else begin
        // marker reached bit 0: this is the fifth write, commit by address
        sr_q     <= SR_INIT;
        sr_cnt_q <= '0;
        case (prg_a_in[14:13])
          REG_CTRL: ctrl_q <= sr_d;
          REG_CHR0: chr0_q <= sr_d;
          REG_CHR1: chr1_q <= sr_d;
          default:  prg_q  <= sr_d;
        endcase
      end
    end
  end

  always_comb begin
    prg_bank_out = '0;
    case (ctrl_q[3:2])
      2'd0, 2'd1: prg_bank_out = PRG_W'({prg_q[3:1], prg_a_in[14]});
      2'd2:       prg_bank_out = prg_a_in[14] ? PRG_W'(prg_q[3:0]) : '0;
      default:    prg_bank_out = prg_a_in[14] ? PRG_LAST : PRG_W'(prg_q[3:0]);
    endcase
  end

  always_comb begin
    chr_bank_out = '0;
    if (!ctrl_q[4]) chr_bank_out = CHR_W'({chr0_q[4:1], chr_a_in[12]});
    else            chr_bank_out = chr_a_in[12] ? CHR_W'(chr1_q) : CHR_W'(chr0_q);
  end

  always_comb begin
    ciram_a10_out = 1'b0;
    case (ctrl_q[1:0])
      MIR_ONE0: ciram_a10_out = 1'b0;
      MIR_ONE1: ciram_a10_out = 1'b1;
      MIR_VERT: ciram_a10_out = chr_a_in[10];
      default:  ciram_a10_out = chr_a_in[11];
    endcase
  end

  assign wram_en_out = ~prg_q[4];
  assign sr_cnt_out  = sr_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{prg_a_in[12:0], prg_d_in[6:1], chr_a_in[13], chr_a_in[9:0]};

endmodule
